// File: rtl/sync_glitch_filter.sv
// Synchronizes an asynchronous level and rebuilds a clean copy on the clock,
// rejecting pulses shorter than STABLE_CYCLES samples and counting them.
module sync_glitch_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 8,
  parameter bit RESET_VALUE   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a,
  input  logic                 clr_count,
  output logic                 y,
  output logic                 rise,
  output logic                 fall,
  output logic                 glitch,
  output logic [CNT_WIDTH-1:0] glitch_count
);

  localparam int                   RW       = $clog2(STABLE_CYCLES) + 1;
  localparam logic [RW-1:0]        RUN_LAST = RW'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  typedef enum logic {STABLE, CANDIDATE} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q, state_d;
  logic [RW-1:0]          run_q, run_d;
  logic                   y_q, y_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   glitch_q, glitch_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= {SYNC_STAGES{RESET_VALUE}};
      state_q  <= STABLE;
      run_q    <= '0;
      y_q      <= RESET_VALUE;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], a};
      state_q  <= state_d;
      run_q    <= run_d;
      y_q      <= y_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    y_d      = y_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = 1'b0;
    case (state_q)
      STABLE: begin
        run_d = '0;
        if (s != y_q) begin
          // A single-sample filter commits on the first differing sample.
          if (STABLE_CYCLES == 1) begin
            y_d    = s;
            rise_d = s;
            fall_d = ~s;
          end else begin
            state_d = CANDIDATE;
            run_d   = RW'(1);
          end
        end
      end
      CANDIDATE: begin
        if (s == y_q) begin
          glitch_d = 1'b1;
          state_d  = STABLE;
          run_d    = '0;
        end else if (run_q == RUN_LAST) begin
          y_d     = s;
          rise_d  = s;
          fall_d  = ~s;
          state_d = STABLE;
          run_d   = '0;
        end else begin
          run_d = run_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE;
        run_d   = '0;
      end
    endcase

    // Clear wins over a coincident glitch.
    if (clr_count)
      cnt_d = '0;
    else if (glitch_d && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + 1'b1;
    else
      cnt_d = cnt_q;
  end

  assign y            = y_q;
  assign rise         = rise_q;
  assign fall         = fall_q;
  assign glitch       = glitch_q;
  assign glitch_count = cnt_q;

endmodule

// File: tb/tb_sync_glitch_filter.sv
// Bench for sync_glitch_filter: directed scenarios on three parameterizations
// plus random levels on the default instance against a run-length model.
module tb_sync_glitch_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic       rst, a, clr;
  logic       y, rise, fall, glitch;
  logic [7:0] gc;
  // CNT_WIDTH=2 instance
  logic       rst2, a2, clr2;
  logic       y2, rise2, fall2, glitch2;
  logic [1:0] gc2;
  // STABLE_CYCLES=1 instance
  logic       rst3, a3, clr3;
  logic       y3, rise3, fall3, glitch3;
  logic [7:0] gc3;

  int checks = 0;
  int passed = 0;

  sync_glitch_filter dut (
    .clk(clk), .rst(rst), .a(a), .clr_count(clr),
    .y(y), .rise(rise), .fall(fall), .glitch(glitch), .glitch_count(gc));

  sync_glitch_filter #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst2), .a(a2), .clr_count(clr2),
    .y(y2), .rise(rise2), .fall(fall2), .glitch(glitch2), .glitch_count(gc2));

  sync_glitch_filter #(.STABLE_CYCLES(1), .SYNC_STAGES(2)) dut_min (
    .clk(clk), .rst(rst3), .a(a3), .clr_count(clr3),
    .y(y3), .rise(rise3), .fall(fall3), .glitch(glitch3), .glitch_count(gc3));

  // Reference for the default instance: s is a delayed by two samples; y flips
  // once four consecutive samples disagree with it, a shorter run is a glitch.
  bit mq[$];
  bit my, mrise, mfall, mglitch;
  int mrun, mcnt;

  task automatic model_step();
    bit s;
    if (rst) begin
      mq = {1'b0, 1'b0};
      my = 1'b0; mrise = 1'b0; mfall = 1'b0; mglitch = 1'b0;
      mrun = 0; mcnt = 0;
    end else begin
      s = mq.pop_front();
      mq.push_back(a);
      mrise = 1'b0; mfall = 1'b0; mglitch = 1'b0;
      if (s != my) begin
        mrun++;
        if (mrun == 4) begin
          my = s; mrise = s; mfall = !s; mrun = 0;
        end
      end else begin
        if (mrun > 0) begin
          mglitch = 1'b1;
          if (mcnt < 255) mcnt++;
        end
        mrun = 0;
      end
      if (clr) mcnt = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; a = 1'b1; clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({y, rise, fall, glitch, gc} !== 12'h000)
        $display("FAIL reset_state cyc%0d: y=%0b r=%0b f=%0b g=%0b cnt=%0d, want all 0",
                 k, y, rise, fall, glitch, gc);
      else passed++;
    end
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (y !== (k >= 6) || rise !== (k == 6))
        $display("FAIL reset_rise edge%0d: y=%0b rise=%0b, want y=%0b rise=%0b",
                 k, y, rise, k >= 6, k == 6);
      else passed++;
    end
  endtask

  task automatic test_clean_fall();
    a = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (y !== (k < 6) || fall !== (k == 6) || glitch !== 1'b0 || rise !== 1'b0)
        $display("FAIL clean_fall edge%0d: y=%0b fall=%0b g=%0b r=%0b, want y=%0b fall=%0b g=0 r=0",
                 k, y, fall, glitch, rise, k < 6, k == 6);
      else passed++;
    end
  endtask

  task automatic test_threshold();
    int ng, nr, nf, nhi;
    // 3-period pulse: rejected
    ng = 0; nhi = 0; nr = 0;
    for (int k = 1; k <= 13; k++) begin
      a = (k <= 3);
      tick();
      ng += int'(glitch); nhi += int'(y); nr += int'(rise);
    end
    checks++;
    if (ng != 1 || nhi != 0 || nr != 0 || gc !== 8'd1)
      $display("FAIL short_pulse: glitches=%0d yhigh=%0d rises=%0d cnt=%0d, want 1 0 0 1",
               ng, nhi, nr, gc);
    else passed++;
    // 4-period pulse: accepted
    ng = 0; nhi = 0; nr = 0; nf = 0;
    for (int k = 1; k <= 14; k++) begin
      a = (k <= 4);
      tick();
      ng += int'(glitch); nhi += int'(y); nr += int'(rise); nf += int'(fall);
    end
    checks++;
    if (ng != 0 || nhi != 4 || nr != 1 || nf != 1 || gc !== 8'd1 || y !== 1'b0)
      $display("FAIL exact_pulse: glitches=%0d yhigh=%0d rises=%0d falls=%0d cnt=%0d y=%0b, want 0 4 1 1 1 0",
               ng, nhi, nr, nf, gc, y);
    else passed++;
  endtask

  task automatic test_reset_mid();
    a = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (y !== 1'b0 || glitch !== 1'b0 || gc !== 8'd0 || rise !== 1'b0)
      $display("FAIL reset_mid: y=%0b g=%0b cnt=%0d r=%0b, want 0 0 0 0", y, glitch, gc, rise);
    else passed++;
    rst = 1'b0; a = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (glitch !== 1'b0 || y !== 1'b0 || gc !== 8'd0)
        $display("FAIL reset_mid_after edge%0d: g=%0b y=%0b cnt=%0d, want 0 0 0", k, glitch, y, gc);
      else passed++;
    end
  endtask

  task automatic test_random();
    int left = 0;
    for (int k = 0; k < 600; k++) begin
      if (left == 0) begin
        a = ~a;
        left = $urandom_range(1, 7);
      end
      left--;
      clr = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 149) == 0);
      tick();
      checks++;
      if ({y, rise, fall, glitch} !== {my, mrise, mfall, mglitch} || gc !== 8'(mcnt))
        $display("FAIL random cyc%0d: y/r/f/g=%0b%0b%0b%0b cnt=%0d, want %0b%0b%0b%0b cnt=%0d",
                 k, y, rise, fall, glitch, gc, my, mrise, mfall, mglitch, mcnt);
      else passed++;
      checks++;
      if ($countones({rise, fall, glitch}) > 1)
        $display("FAIL exclusive cyc%0d: r=%0b f=%0b g=%0b, want at most one", k, rise, fall, glitch);
      else passed++;
    end
    rst = 1'b0; clr = 1'b0;
  endtask

  task automatic test_saturation();
    logic [1:0] e;
    rst2 = 1'b1; a2 = 1'b0; clr2 = 1'b0;
    tick(); tick();
    rst2 = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    for (int p = 1; p <= 6; p++) begin
      for (int t = 1; t <= 8; t++) begin
        a2   = (t <= 2);
        clr2 = (p == 6 && t == 5);
        tick();
        checks++;
        if (glitch2 !== (t == 5) || y2 !== 1'b0 || rise2 !== 1'b0 || fall2 !== 1'b0)
          $display("FAIL sat_pulse p%0d t%0d: g=%0b y=%0b r=%0b f=%0b, want g=%0b y=0 r=0 f=0",
                   p, t, glitch2, y2, rise2, fall2, t == 5);
        else passed++;
        if (t == 5) begin
          e = (p == 6) ? 2'd0 : 2'((p > 3) ? 3 : p);
          checks++;
          if (gc2 !== e)
            $display("FAIL sat_count p%0d: cnt=%0d, want %0d", p, gc2, e);
          else passed++;
        end
      end
    end
    clr2 = 1'b0;
  endtask

  task automatic test_min_filter();
    rst3 = 1'b1; a3 = 1'b0; clr3 = 1'b0;
    tick();
    rst3 = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    for (int k = 1; k <= 8; k++) begin
      a3 = (k == 1);
      tick();
      checks++;
      if (y3 !== (k == 3) || rise3 !== (k == 3) || fall3 !== (k == 4) ||
          glitch3 !== 1'b0 || gc3 !== 8'd0)
        $display("FAIL min_filter edge%0d: y=%0b r=%0b f=%0b g=%0b cnt=%0d, want y=%0b r=%0b f=%0b g=0 cnt=0",
                 k, y3, rise3, fall3, glitch3, gc3, k == 3, k == 3, k == 4);
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; a = 1'b1; clr = 1'b0;
    rst2 = 1'b1; a2 = 1'b0; clr2 = 1'b0;
    rst3 = 1'b1; a3 = 1'b0; clr3 = 1'b0;
    test_reset();
    test_clean_fall();
    test_threshold();
    test_reset_mid();
    test_random();
    test_saturation();
    test_min_filter();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
